// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction at a time from instruction
// memory, holds it until downstream consumes it, then advances pc.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        pcsrc,
    input  logic [31:0] branch_offset,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID
    } state_t;

    state_t      state_q;
    logic        imem_req_q;
    logic        instr_valid_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [15:0] retired_q;
    logic [15:0] retired_d;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    assign pc_plus4      = pc_q + 32'd4;
    assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    assign branch_target = pc_plus4 + (branch_offset << 2);

    // Jump outranks branch when the control unit raises both.
    always_comb begin
        next_pc = pc_plus4;
        if (pcsrc) begin
            next_pc = jump_target;
        end else if (branch) begin
            next_pc = branch_target;
        end
    end

    assign pc_d      = next_pc & ~32'd3;
    assign retired_d = retired_q + 16'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            pc_q          <= RESET_PC & ~32'd3;
            instr_q       <= 32'd0;
            retired_q     <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        state_q       <= VALID;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        instr_q       <= imem_rdata;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        state_q       <= FETCH;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
                        pc_q          <= pc_d;
                        retired_q     <= retired_d;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one DUT at the default reset pc, a second at
// 32'hFFFF_FFFC to exercise pc wrap-around; both share all inputs.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        pcsrc;
    logic [31:0] branch_offset;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [15:0] retired;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_instr;
    logic [5:0]  w_opcode;
    logic        w_instr_valid;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [15:0] w_retired;

    int checks;
    int errors;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .branch(branch), .pcsrc(pcsrc), .branch_offset(branch_offset),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc),
        .pc_plus4(pc_plus4), .retired(retired)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .branch(branch), .pcsrc(pcsrc), .branch_offset(branch_offset),
        .instr(w_instr), .opcode(w_opcode), .instr_valid(w_instr_valid), .pc(w_pc),
        .pc_plus4(w_pc_plus4), .retired(w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: return word on the first cycle, consume it, end back in FETCH.
    task automatic fetch_consume(input logic [31:0] word);
        imem_rdata = word;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        stall      = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (opcode !== 6'h00) begin errors++; $display("FAIL reset_opcode: got %h expected 00", opcode); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h expected 00000004", pc_plus4); end
        checks++; if (retired !== 16'h0) begin errors++; $display("FAIL reset_retired: got %h expected 0000", retired); end
        checks++; if (w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_w_pc: got %h expected fffffffc", w_pc); end
        checks++; if (w_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_w_pc_plus4: got %h expected 00000000", w_pc_plus4); end
        rst        = 1'b0;
        imem_ready = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL idle_to_fetch_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL idle_to_fetch_addr: got %h expected 00000000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_to_fetch_valid: got %b expected 0", instr_valid); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_addr !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, 32'(i * 4)); end
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d]: got %b expected 1", i, imem_req); end
            imem_rdata = 32'h2000_0000 | 32'(i);
            imem_ready = 1'b1;
            step();
            imem_ready = 1'b0;
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid_hi[%0d]: got %b expected 1", i, instr_valid); end
            checks++; if (instr !== (32'h2000_0000 | 32'(i))) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, instr, 32'h2000_0000 | 32'(i)); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_req_lo[%0d]: got %b expected 0", i, imem_req); end
            step();
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_lo[%0d]: got %b expected 0", i, instr_valid); end
        end
        checks++; if (retired !== 16'd3) begin errors++; $display("FAIL seq_retired: got %0d expected 3", retired); end
    endtask

    task automatic test_mem_wait();
        fetch_consume(32'h0);
        imem_ready = 1'b0;
        imem_rdata = 32'h1111_1111;
        for (int k = 0; k < 5; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL wait_req_addr[%0d]: got req=%b addr=%h expected req=1 addr=00000010", k, imem_req, imem_addr); end
            checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL wait_hold[%0d]: got valid=%b instr=%h expected valid=0 instr=00000000", k, instr_valid, instr); end
            step();
        end
        imem_rdata = 32'h8C01_0004;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C01_0004) begin errors++; $display("FAIL wait_load: got valid=%b instr=%h expected valid=1 instr=8c010004", instr_valid, instr); end
    endtask

    task automatic test_stall();
        stall         = 1'b1;
        branch        = 1'b1;
        pcsrc         = 1'b1;
        branch_offset = 32'h0000_0100;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (instr !== 32'h8C01_0004 || opcode !== 6'h23) begin errors++; $display("FAIL stall_instr[%0d]: got instr=%h opcode=%h expected 8c010004/23", k, instr, opcode); end
            checks++; if (pc !== 32'h10 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_pc[%0d]: got pc=%h valid=%b expected 00000010/1", k, pc, instr_valid); end
        end
        stall  = 1'b0;
        branch = 1'b0;
        pcsrc  = 1'b0;
        step();
        checks++; if (pc !== 32'h14 || imem_req !== 1'b1) begin errors++; $display("FAIL stall_release: got pc=%h req=%b expected 00000014/1", pc, imem_req); end
        checks++; if (retired !== 16'd5) begin errors++; $display("FAIL stall_retired: got %0d expected 5", retired); end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 3; k++) fetch_consume(32'h0);
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL branch_setup_pc: got %h expected 00000020", pc); end
        branch        = 1'b1;
        pcsrc         = 1'b1;
        branch_offset = 32'hFFFF_FFFE;
        imem_ready    = 1'b0;
        step();
        checks++; if (pc !== 32'h20 || imem_req !== 1'b1) begin errors++; $display("FAIL branch_ignored_fetch: got pc=%h req=%b expected 00000020/1", pc, imem_req); end
        pcsrc      = 1'b0;
        imem_rdata = 32'h0800_0040;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        checks++; if (pc !== 32'h1C || imem_addr !== 32'h1C) begin errors++; $display("FAIL branch_target: got pc=%h addr=%h expected 0000001c", pc, imem_addr); end
        branch = 1'b0;
        fetch_consume(32'h0);
        imem_rdata = 32'h0800_0040;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        pcsrc      = 1'b1;
        branch     = 1'b1;
        step();
        pcsrc  = 1'b0;
        branch = 1'b0;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jump_priority: got %h expected 00000100", pc); end
        checks++; if (retired !== 16'd11) begin errors++; $display("FAIL branch_retired: got %0d expected 11", retired); end
    endtask

    task automatic test_retired_wrap();
        imem_ready = 1'b0;
        force dut.retired_q = 16'hFFFF;
        step();
        release dut.retired_q;
        checks++; if (retired !== 16'hFFFF) begin errors++; $display("FAIL retired_preset: got %h expected ffff", retired); end
        fetch_consume(32'h0);
        checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL retired_wrap: got %h expected 0000", retired); end
    endtask

    task automatic test_pc_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch: got req=%b addr=%h expected 1/fffffffc", w_imem_req, w_imem_addr); end
        fetch_consume(32'h0);
        checks++; if (w_pc !== 32'h0 || w_imem_req !== 1'b1) begin errors++; $display("FAIL wrap_pc: got pc=%h req=%b expected 00000000/1", w_pc, w_imem_req); end
        checks++; if (w_pc_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_pc_plus4: got %h expected 00000004", w_pc_plus4); end
    endtask

    task automatic test_reset_mid_fetch();
        for (int k = 0; k < 15; k++) fetch_consume(32'h0);
        checks++; if (pc !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL midrst_setup: got pc=%h req=%b expected 00000040/1", pc, imem_req); end
        rst        = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        checks++; if (pc !== 32'h0 || instr !== 32'h0) begin errors++; $display("FAIL midrst_state: got pc=%h instr=%h expected 0/0", pc, instr); end
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got valid=%b req=%b expected 0/0", instr_valid, imem_req); end
        checks++; if (retired !== 16'h0) begin errors++; $display("FAIL midrst_retired: got %h expected 0000", retired); end
        rst = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_refetch: got req=%b addr=%h valid=%b expected 1/00000000/0", imem_req, imem_addr, instr_valid); end
        imem_ready = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;
        stall         = 1'b0;
        branch        = 1'b0;
        pcsrc         = 1'b0;
        branch_offset = 32'h0;
        test_reset();
        test_sequential();
        test_mem_wait();
        test_stall();
        test_branch();
        test_retired_wrap();
        test_pc_wrap();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the address of the first instruction fetched after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-005 SHALL have port imem_addr, output, 32, byte address of the requested instruction; equals pc.
REQ-006 SHALL have port imem_ready, input, 1, memory indicates imem_rdata is valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, instruction word from memory.
REQ-008 SHALL have port stall, input, 1, downstream cannot consume the held instruction this cycle.
REQ-009 SHALL have port branch, input, 1, taken-branch indication from the control unit for the held instruction.
REQ-010 SHALL have port pcsrc, input, 1, jump indication from the control unit for the held instruction.
REQ-011 SHALL have port branch_offset, input, 32, sign-extended word offset of the branch.
REQ-012 SHALL have port instr, output, 32, held instruction register.
REQ-013 SHALL have port opcode, output, 6, instr[31:26], feeding the control unit.
REQ-014 SHALL have port instr_valid, output, 1, instr holds a fetched, unconsumed instruction.
REQ-015 SHALL have port pc, output, 32, address of the held or in-flight instruction.
REQ-016 SHALL have port pc_plus4, output, 32, pc + 4, combinational.
REQ-017 SHALL have port retired, output, 16, count of consumed instructions.

Function
REQ-018 SHALL implement states IDLE, FETCH, VALID.
REQ-019 SHALL move IDLE -> FETCH unconditionally on the cycle after rst deasserts.
REQ-020 SHALL drive imem_req = 1 only in FETCH, with imem_addr = pc held stable until imem_ready.
REQ-021 SHALL, in FETCH with imem_ready = 1, load instr <= imem_rdata and enter VALID; instr_valid rises the next cycle (latency 1 after ready).
REQ-022 SHALL remain in FETCH with instr and pc unchanged while imem_ready = 0, with no timeout.
REQ-023 SHALL drive instr_valid = 1 exactly while in VALID.
REQ-024 SHALL, in VALID with stall = 1, hold instr, pc and state, and ignore branch and pcsrc.
REQ-025 SHALL, in VALID with stall = 0, consume the instruction, enter FETCH and update pc on that edge.
REQ-026 SHALL compute the next pc as: pcsrc = 1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch = 1 -> pc_plus4 + (branch_offset << 2); else pc_plus4.
REQ-027 SHALL give pcsrc priority over branch when both are asserted.
REQ-028 SHALL perform all pc arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-029 SHALL force pc[1:0] = 2'b00 at all times.
REQ-030 SHALL increment retired by 1 on each consume, wrapping 16'hFFFF -> 16'h0000.
REQ-031 SHALL ignore imem_ready in IDLE and VALID.
REQ-032 SHALL ignore branch and pcsrc outside VALID.

Reset
REQ-033 SHALL, on any clk edge with rst = 1, regardless of state (including mid-fetch), set state = IDLE, pc = RESET_PC, instr = 0, retired = 0.
REQ-034 SHALL output imem_req = 0, instr_valid = 0, opcode = 0 and pc_plus4 = RESET_PC + 4 during and immediately after reset.
REQ-035 SHALL ensure that an imem_ready arriving in the reset cycle neither loads instr nor changes state.

Verification
REQ-036 SHALL cover sequential fetch: rst for 2 cycles, then imem_ready = 1 every FETCH cycle, stall = 0 -> imem_addr = 0, 4, 8; instr_valid pulses 1 of every 2 cycles; retired = 3 after three consumes.
REQ-037 SHALL cover memory wait: imem_ready held 0 for 5 cycles in FETCH with pc = 32'h10 -> imem_req = 1 and imem_addr = 32'h10 stable for all 5 cycles; instr loads on the ready cycle.
REQ-038 SHALL cover stall: stall = 1 for 3 cycles in VALID with instr = 32'h8C01_0004 -> instr, opcode = 6'h23 and pc unchanged; branch = 1 during the stall has no effect.
REQ-039 SHALL cover branch and jump: pc = 32'h20, branch = 1, branch_offset = 32'hFFFF_FFFE -> next pc = 32'h1C; pc = 32'h20, instr = 32'h0800_0040, pcsrc = 1 and branch = 1 -> next pc = 32'h100.
REQ-040 SHALL cover wrap-around: RESET_PC = 32'hFFFF_FFFC, one sequential consume -> pc = 0; retired at 16'hFFFF with one consume -> 16'h0000.
REQ-041 SHALL cover reset mid-fetch: rst = 1 in FETCH with pc = 32'h40, coincident with imem_ready = 1 -> pc = RESET_PC, instr = 0, instr_valid = 0, IDLE then FETCH at RESET_PC.
